// File: rtl/register_file_sb.sv
// ============================================================================
// register_file_sb : 2-read/2-write register file with per-register busy
//                    (scoreboard) bits and a registered pending-write count
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file_sb #(
   parameter int XLEN     = 32,
   parameter int REGS     = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(REGS)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] di3,
   input  logic            we3,
   input  logic [AW-1:0]   a4,
   input  logic [XLEN-1:0] di4,
   input  logic            we4,
   input  logic [AW-1:0]   ar,
   input  logic            re,
   output logic [AW:0]     pend_cnt
);

   logic [XLEN-1:0] regs [REGS];
   logic [REGS-1:0] busy;
   logic [REGS-1:0] busy_nxt;
   logic [AW:0]     pend_nxt;
   logic            wr3, wr4, rsv;
   logic            inc, clr3, clr4;

   // Accesses aimed at a hardwired zero register are dropped entirely.
   assign wr3 = we3 && !(ZERO_REG != 0 && a3 == '0);
   assign wr4 = we4 && !(ZERO_REG != 0 && a4 == '0);
   assign rsv = re  && !(ZERO_REG != 0 && ar == '0);

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      v = regs[a];
      if (ZERO_REG != 0 && a == '0)
         v = '0;
      else if (BYPASS != 0 && wr3 && a3 == a)
         v = di3;
      else if (BYPASS != 0 && wr4 && a4 == a)
         v = di4;
      return v;
   endfunction

   function automatic logic busy_port(input logic [AW-1:0] a);
      logic hit_wr;
      hit_wr = (wr3 && a3 == a) || (wr4 && a4 == a);
      return busy[a] && !(BYPASS != 0 && hit_wr && !(rsv && ar == a));
   endfunction

   always_comb begin
      rd1   = read_port(a1);
      rd2   = read_port(a2);
      busy1 = busy_port(a1);
      busy2 = busy_port(a2);
   end

   // Reserve is applied last so it wins over a same-cycle clear.
   always_comb begin
      busy_nxt = busy;
      if (wr3) busy_nxt[a3] = 1'b0;
      if (wr4) busy_nxt[a4] = 1'b0;
      if (rsv) busy_nxt[ar] = 1'b1;
   end

   // Count deltas mirror busy_nxt: a clear only counts if the bit was set,
   // is not re-reserved, and was not already cleared by the other port.
   always_comb begin
      inc      = rsv && !busy[ar];
      clr3     = wr3 && busy[a3] && !(rsv && ar == a3);
      clr4     = wr4 && busy[a4] && !(rsv && ar == a4) && !(wr3 && a3 == a4);
      pend_nxt = pend_cnt + (AW+1)'(inc) - (AW+1)'(clr3) - (AW+1)'(clr4);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REGS; i++)
            regs[i] <= '0;
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         if (wr4) regs[a4] <= di4;
         if (wr3) regs[a3] <= di3;
         busy     <= busy_nxt;
         pend_cnt <= pend_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// tb_register_file_sb : directed + random bench for register_file_sb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file_sb;

   localparam int XLEN = 32;
   localparam int REGS = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [AW-1:0]   a1, a2, a3, a4, ar;
   logic [XLEN-1:0] di3, di4;
   logic            we3, we4, re;

   logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic            busy1_b, busy2_b, busy1_n, busy2_n;
   logic [AW:0]     pend_b, pend_n;

   int total = 0;
   int bad   = 0;

   logic [XLEN-1:0] m_reg [REGS];
   bit              m_busy [REGS];

   always #5 clk = ~clk;

   register_file_sb #(.XLEN(XLEN), .REGS(REGS), .ZERO_REG(1), .BYPASS(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
      .busy1(busy1_b), .busy2(busy2_b), .a3(a3), .di3(di3), .we3(we3),
      .a4(a4), .di4(di4), .we4(we4), .ar(ar), .re(re), .pend_cnt(pend_b));

   register_file_sb #(.XLEN(XLEN), .REGS(REGS), .ZERO_REG(1), .BYPASS(0)) dut_n (
      .clk(clk), .reset_n(reset_n), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
      .busy1(busy1_n), .busy2(busy2_n), .a3(a3), .di3(di3), .we3(we3),
      .a4(a4), .di4(di4), .we4(we4), .ar(ar), .re(re), .pend_cnt(pend_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < REGS; i++) n += m_busy[i] ? 1 : 0;
      return n;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 32'd0;
      if (byp && we3 && a3 == a) return di3;
      if (byp && we4 && a4 == a) return di4;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      bit written = (we3 && a3 == a) || (we4 && a4 == a);
      bit reserved = re && ar == a;
      if (a == 0) return 1'b0;
      if (byp && written && !reserved) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < REGS; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (we4 && a4 != 0) begin m_reg[a4] = di4; m_busy[a4] = 1'b0; end
      if (we3 && a3 != 0) begin m_reg[a3] = di3; m_busy[a3] = 1'b0; end
      if (re && ar != 0) m_busy[ar] = 1'b1;
   endtask

   task automatic idle();
      we3 = 0; we4 = 0; re = 0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic cycle();
      #1;
      chk("rd1_byp",   rd1_b,   exp_rd(a1, 1));
      chk("rd2_byp",   rd2_b,   exp_rd(a2, 1));
      chk("busy1_byp", {31'd0, busy1_b}, {31'd0, exp_busy(a1, 1)});
      chk("busy2_byp", {31'd0, busy2_b}, {31'd0, exp_busy(a2, 1)});
      chk("rd1_nobyp", rd1_n,   exp_rd(a1, 0));
      chk("rd2_nobyp", rd2_n,   exp_rd(a2, 0));
      chk("busy1_nobyp", {31'd0, busy1_n}, {31'd0, exp_busy(a1, 0)});
      @(posedge clk);
      model_edge();
      #1;
      chk("pend_byp",  {26'd0, pend_b}, model_count());
      chk("pend_nobyp", {26'd0, pend_n}, model_count());
      @(negedge clk);
   endtask

   initial begin
      reset_n = 0;
      idle();
      a1 = 5'd1; a2 = 5'd10; a3 = 0; a4 = 0; ar = 0; di3 = 0; di4 = 0;
      model_reset();
      #12;
      chk("reset_rd1", rd1_b, 32'd0);
      chk("reset_rd2", rd2_b, 32'd0);
      chk("reset_busy", {30'd0, busy1_b, busy2_b}, 32'd0);
      chk("reset_pend", {26'd0, pend_b}, 32'd0);
      // Stimulus during reset must be ignored.
      we3 = 1; a3 = 5'd3; di3 = 32'h1234; re = 1; ar = 5'd3;
      @(posedge clk); #1;
      chk("reset_ignore_pend", {26'd0, pend_b}, 32'd0);
      @(negedge clk);
      idle();
      reset_n = 1;
      a1 = 5'd3; a2 = 5'd1;
      cycle();

      // Bypass of a fresh write, then stored value.
      we3 = 1; a3 = 5'd1; di3 = 32'd69; a1 = 5'd1;
      #1;
      chk("byp_before_edge", rd1_b, 32'd69);
      chk("nobyp_before_edge", rd1_n, 32'd0);
      cycle();
      idle();
      #1;
      chk("stored_after_edge", rd1_b, 32'd69);
      cycle();

      // Same-address dual write: port 3 wins; writes to reg0 dropped.
      we3 = 1; we4 = 1; a3 = 5'd5; a4 = 5'd5; di3 = 32'hAAAA_AAAA; di4 = 32'h5555_5555;
      a1 = 5'd5;
      cycle();
      idle();
      #1;
      chk("dual_write_prio", rd1_b, 32'hAAAA_AAAA);
      we3 = 1; a3 = 5'd0; di3 = 32'd7; a1 = 5'd0;
      cycle();
      idle();
      #1;
      chk("zero_reg", rd1_b, 32'd0);

      // Reserve, reserve-vs-write, then clear.
      re = 1; ar = 5'd7; a1 = 5'd7;
      cycle();
      idle();
      #1;
      chk("rsv_busy", {31'd0, busy1_b}, 32'd1);
      chk("rsv_pend", {26'd0, pend_b}, 32'd1);
      we4 = 1; a4 = 5'd7; di4 = 32'hCAFE; re = 1; ar = 5'd7;
      cycle();
      idle();
      #1;
      chk("rsv_wins_busy", {31'd0, busy1_b}, 32'd1);
      chk("rsv_wins_pend", {26'd0, pend_b}, 32'd1);
      we4 = 1; a4 = 5'd7; di4 = 32'hBEEF;
      cycle();
      idle();
      #1;
      chk("clr_busy", {31'd0, busy1_b}, 32'd0);
      chk("clr_pend", {26'd0, pend_b}, 32'd0);

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         a1 = AW'($urandom); a2 = AW'($urandom);
         a3 = AW'($urandom); a4 = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom);
         ar = ($urandom_range(0, 3) == 0) ? a4 : AW'($urandom);
         di3 = $urandom; di4 = $urandom;
         we3 = $urandom_range(0, 2) == 0;
         we4 = $urandom_range(0, 2) == 0;
         re  = $urandom_range(0, 1) == 0;
         cycle();
      end
      idle();

      // Fill the scoreboard completely; reg0 reserve is ignored.
      reset_n = 0; #1; model_reset(); reset_n = 1;
      for (int r = 1; r < REGS; r++) begin
         re = 1; ar = AW'(r);
         cycle();
      end
      idle();
      #1;
      chk("full_pend", {26'd0, pend_b}, 32'd31);
      re = 1; ar = 5'd0;
      cycle();
      idle();
      #1;
      chk("rsv_zero_pend", {26'd0, pend_b}, 32'd31);

      // Populate data, then assert reset in the middle of a clock phase.
      we3 = 1; a3 = 5'd9; di3 = 32'h0F0F_0F0F;
      cycle();
      idle();
      a1 = 5'd9; a2 = 5'd12;
      @(posedge clk); #2;
      reset_n = 0;
      #1;
      chk("async_pend", {26'd0, pend_b}, 32'd0);
      chk("async_rd1", rd1_b, 32'd0);
      chk("async_rd2", rd2_b, 32'd0);
      chk("async_busy2", {31'd0, busy2_b}, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1;
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
